// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
//
// Byte-stream coefficient loader placed directly ahead of the FIR filter's
// coefficient port. Bytes arrive over a valid/ready handshake. Each pair of
// bytes is assembled little-endian into one coefficient, which is then
// written to the filter with a single-cycle c_WE pulse at a sequential
// address. The session ends after NUM_COEFF writes.
//
// Optional feature (compile-time macro FIR_COEFF_LOADER_CHECKSUM_EN):
//   When defined, one extra byte follows the table. It must equal the 8-bit
//   XOR of every coefficient byte in the session; otherwise err is raised.
//   When undefined, there is no checksum byte and err is tied low.
//
// Parameters
//   NUM_COEFF   coefficients per table
//   COEFF_SIZE  coefficient width (two bytes, so 16)
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse that opens a session (ignored while busy)
//   byte_in     stream byte
//   byte_valid  byte_in carries a byte
//   byte_ready  loader takes a byte this cycle
//   c_WE        coefficient write strobe to the filter
//   c_in        coefficient value (registered, held between writes)
//   c_addr      coefficient index (registered, held between writes)
//   busy        session in progress
//   done        table loaded (and checksum matched, when enabled)
//   err         checksum mismatch
// ---------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter int NUM_COEFF  = 129,
    parameter int COEFF_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic                         c_WE,
    output logic [COEFF_SIZE-1:0]        c_in,
    output logic [$clog2(NUM_COEFF)-1:0] c_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int            AW       = $clog2(NUM_COEFF);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_COEFF - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WR   = 3'd3,
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
        S_CHK  = 3'd4,
        S_ERR  = 3'd6,
`endif
        S_DONE = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] index;
    logic [7:0]    lo_byte;
    logic          accept;
    logic          start_ok;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    assign accept   = byte_valid && byte_ready;
    assign start_ok = start && !busy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        c_WE       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_nxt = S_HI;
            end
            S_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_nxt = S_WR;
            end
            S_WR: begin
                c_WE = 1'b1;
                busy = 1'b1;
                if (index == LAST_IDX) begin
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                    state_nxt = S_CHK;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_LO;
                end
            end
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            S_CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_nxt = (byte_in == checksum) ? S_DONE : S_ERR;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_nxt = S_LO;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_LO;
            end
            // S_IDLE; any unused encoding also waits here for start
            default: begin
                if (start) state_nxt = S_LO;
            end
        endcase
    end

    // Assembly datapath: c_in/c_addr are loaded on the edge that accepts
    // the high byte so they are already valid during the WR cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            index  <= '0;
            c_in   <= '0;
            c_addr <= '0;
        end else begin
            if (start_ok) begin
                index <= '0;
            end else if (state == S_WR && index != LAST_IDX) begin
                index <= index + AW'(1);
            end
            if (accept && state == S_HI) begin
                c_in   <= COEFF_SIZE'({byte_in, lo_byte});
                c_addr <= index;
            end
        end
    end

    // Low byte is pure data; a stale value is always overwritten before use.
    always_ff @(posedge clk) begin
        if (accept && state == S_LO) lo_byte <= byte_in;
    end

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    // Running XOR over coefficient bytes only; the checksum byte is excluded.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            checksum <= '0;
        end else if (accept && (state == S_LO || state == S_HI)) begin
            checksum <= checksum ^ byte_in;
        end
    end
`endif

endmodule
